// File: rtl/simd_addsub_pipe.sv
// Two-stage packed-lane SIMD adder/subtractor (1x, 2x or 4x lanes) with per-lane flags.
// Optional lane saturation is compiled in with the ADDSUB_SATURATE_EN macro.
module simd_addsub_pipe #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             SUB,
    input  logic [1:0]       MODE,
    input  logic             SAT,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] S,
    output logic [3:0]       OVF,
    output logic [3:0]       NEG,
    output logic [3:0]       CO
);

    localparam int NSEG  = 4;
    localparam int SEG_W = WIDTH / NSEG;

    typedef logic [SEG_W:0] seg_sum_t;
    typedef enum logic [1:0] {
        MODE_1X   = 2'b00,
        MODE_2X   = 2'b01,
        MODE_4X   = 2'b10,
        MODE_RSVD = 2'b11
    } mode_e;

    // Lane geometry: which segments open a lane, close a lane, and which lane they belong to.
    function automatic logic seg_start(input mode_e m, input int k);
        case (m)
            MODE_4X: return 1'b1;
            MODE_2X: return (k % 2) == 0;
            default: return k == 0;
        endcase
    endfunction

    function automatic logic seg_top(input mode_e m, input int k);
        case (m)
            MODE_4X: return 1'b1;
            MODE_2X: return (k % 2) == 1;
            default: return k == NSEG - 1;
        endcase
    endfunction

    function automatic logic [1:0] seg_lane(input mode_e m, input int k);
        case (m)
            MODE_4X: return 2'(k);
            MODE_2X: return 2'(k / 2);
            default: return 2'd0;
        endcase
    endfunction

    logic w_adv;
    logic w_accept;

    assign w_adv    = ~OUT_VALID | OUT_READY;
    assign IN_READY = w_adv;
    assign w_accept = IN_VALID & w_adv;

    // Stage 1: per-segment sums for both possible carry-ins.
    logic [WIDTH-1:0] w_bop;
    seg_sum_t         w_sum0 [NSEG];
    seg_sum_t         w_sum1 [NSEG];
    logic [NSEG-1:0]  w_a_msb;
    logic [NSEG-1:0]  w_b_msb;

    // NOTE: every variable in an always_comb gets a value on every path, otherwise a latch is inferred.
    always_comb begin
        w_bop = SUB ? ~B : B;
        for (int k = 0; k < NSEG; k++) begin
            w_sum0[k]  = {1'b0, A[k*SEG_W +: SEG_W]} + {1'b0, w_bop[k*SEG_W +: SEG_W]};
            w_sum1[k]  = {1'b0, A[k*SEG_W +: SEG_W]} + {1'b0, w_bop[k*SEG_W +: SEG_W]} + seg_sum_t'(1);
            w_a_msb[k] = A[k*SEG_W + SEG_W - 1];
            w_b_msb[k] = w_bop[k*SEG_W + SEG_W - 1];
        end
    end

    logic            r_s1_valid;
    seg_sum_t        r_sum0 [NSEG];
    seg_sum_t        r_sum1 [NSEG];
    logic [NSEG-1:0] r_a_msb;
    logic [NSEG-1:0] r_b_msb;
    logic            r_sub;
    mode_e           r_mode;
`ifdef ADDSUB_SATURATE_EN
    logic            r_sat;
`else
    logic            w_sat_unused;
    assign w_sat_unused = SAT;
`endif

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_s1_valid <= 1'b0;
            r_a_msb    <= '0;
            r_b_msb    <= '0;
            r_sub      <= 1'b0;
            r_mode     <= MODE_1X;
`ifdef ADDSUB_SATURATE_EN
            r_sat      <= 1'b0;
`endif
            // NOTE: the sum arrays are plain flops, not RAM, so they are reset with the rest.
            for (int k = 0; k < NSEG; k++) begin
                r_sum0[k] <= '0;
                r_sum1[k] <= '0;
            end
        end else begin
            if (w_adv) begin
                r_s1_valid <= IN_VALID;
            end
            if (w_accept) begin
                r_sum0  <= w_sum0;
                r_sum1  <= w_sum1;
                r_a_msb <= w_a_msb;
                r_b_msb <= w_b_msb;
                r_sub   <= SUB;
                r_mode  <= (MODE == MODE_RSVD) ? MODE_1X : mode_e'(MODE);
`ifdef ADDSUB_SATURATE_EN
                r_sat   <= SAT;
`endif
            end
        end
    end

    // Stage 2: carry-select ripple, restarted with SUB at every lane boundary.
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_s_next;
    logic [NSEG-1:0]  w_cout;
    logic [NSEG-1:0]  w_seg_ovf;
    logic [3:0]       w_ovf;
    logic [3:0]       w_neg;
    logic [3:0]       w_co;

    always_comb begin
        logic     carry;
        seg_sum_t sel;
        logic [1:0] lane;
        carry     = r_sub;
        w_sum     = '0;
        w_cout    = '0;
        w_seg_ovf = '0;
        w_ovf     = '0;
        w_neg     = '0;
        w_co      = '0;
        for (int k = 0; k < NSEG; k++) begin
            if (seg_start(r_mode, k)) begin
                carry = r_sub;
            end
            sel                      = carry ? r_sum1[k] : r_sum0[k];
            w_sum[k*SEG_W +: SEG_W]  = sel[SEG_W-1:0];
            w_cout[k]                = sel[SEG_W];
            // Carry into the segment msb recovered from sum ^ a ^ b at that bit.
            w_seg_ovf[k]             = sel[SEG_W-1] ^ r_a_msb[k] ^ r_b_msb[k] ^ sel[SEG_W];
            carry                    = sel[SEG_W];
        end
        for (int k = 0; k < NSEG; k++) begin
            if (seg_top(r_mode, k)) begin
                lane        = seg_lane(r_mode, k);
                w_ovf[lane] = w_seg_ovf[k];
                w_co[lane]  = w_cout[k];
                w_neg[lane] = w_seg_ovf[k] ^ w_sum[k*SEG_W + SEG_W - 1];
            end
        end
        w_s_next = w_sum;
`ifdef ADDSUB_SATURATE_EN
        for (int k = 0; k < NSEG; k++) begin
            lane = seg_lane(r_mode, k);
            if (r_sat && w_ovf[lane]) begin
                if (seg_top(r_mode, k)) begin
                    w_s_next[k*SEG_W +: SEG_W] = {w_neg[lane], {(SEG_W-1){~w_neg[lane]}}};
                end else begin
                    w_s_next[k*SEG_W +: SEG_W] = {SEG_W{~w_neg[lane]}};
                end
            end
        end
`endif
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            OUT_VALID <= 1'b0;
            S         <= '0;
            OVF       <= '0;
            NEG       <= '0;
            CO        <= '0;
        end else if (w_adv) begin
            OUT_VALID <= r_s1_valid;
            if (r_s1_valid) begin
                S   <= w_s_next;
                OVF <= w_ovf;
                NEG <= w_neg;
                CO  <= w_co;
            end
        end
    end

endmodule

// File: tb/tb_simd_addsub_pipe.sv
// Scoreboard bench for simd_addsub_pipe: directed vectors, stall and async-reset scenarios.
// Expected S for saturating vectors follows ADDSUB_SATURATE_EN.
module tb_simd_addsub_pipe;

    logic        CLK;
    logic        RESET_N;
    logic        IN_VALID;
    logic        IN_READY;
    logic [31:0] A;
    logic [31:0] B;
    logic        SUB;
    logic [1:0]  MODE;
    logic        SAT;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [31:0] S;
    logic [3:0]  OVF;
    logic [3:0]  NEG;
    logic [3:0]  CO;

    simd_addsub_pipe #(.WIDTH(32)) dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .A         (A),
        .B         (B),
        .SUB       (SUB),
        .MODE      (MODE),
        .SAT       (SAT),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .S         (S),
        .OVF       (OVF),
        .NEG       (NEG),
        .CO        (CO)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] s;
        logic [3:0]  ovf;
        logic [3:0]  neg;
        logic [3:0]  co;
        int          cyc;
        bit          chk_lat;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    bit          stalled_prev = 0;
    logic [31:0] held_s;

`ifdef ADDSUB_SATURATE_EN
    localparam bit SAT_ON = 1'b1;
`else
    localparam bit SAT_ON = 1'b0;
`endif

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: pops the scoreboard whenever a result is handed over.
    always @(negedge CLK) begin
        if (RESET_N && OUT_VALID) begin
            if (!OUT_READY) begin
                check("in_ready_while_full", 32'(IN_READY), 32'd0);
                if (stalled_prev) check("s_stable_in_stall", S, held_s);
                stalled_prev = 1'b1;
                held_s       = S;
            end else begin
                stalled_prev = 1'b0;
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_output: got S=%h, expected no output", S);
                end else begin
                    mon_e = sb.pop_front();
                    check("S",   S,          mon_e.s);
                    check("OVF", 32'(OVF),   32'(mon_e.ovf));
                    check("NEG", 32'(NEG),   32'(mon_e.neg));
                    check("CO",  32'(CO),    32'(mon_e.co));
                    if (mon_e.chk_lat) check("latency", 32'(cyc - mon_e.cyc), 32'd2);
                end
            end
        end else begin
            stalled_prev = 1'b0;
        end
    end

    // Driver: called at posedge+1, returns at posedge+1 after the beat is accepted.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic sub,
                        input logic [1:0] mode, input logic sat, input logic [31:0] es,
                        input logic [3:0] eo, input logic [3:0] en, input logic [3:0] ec,
                        input bit lat);
        exp_t e;
        bit   ok;
        A = a; B = b; SUB = sub; MODE = mode; SAT = sat; IN_VALID = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge CLK);
            ok = IN_READY;
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: got IN_READY=0 for 50 cycles, expected 1");
        end else begin
            e.s = es; e.ovf = eo; e.neg = en; e.co = ec; e.cyc = cyc; e.chk_lat = lat;
            sb.push_back(e);
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        IN_VALID = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 100 && sb.size() != 0; t++) @(posedge CLK);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        repeat (3) @(posedge CLK);
        #1;
        check("out_valid_idle", 32'(OUT_VALID), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET_N = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b1;
        A = '0; B = '0; SUB = 1'b0; MODE = 2'b00; SAT = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_out_valid", 32'(OUT_VALID), 32'd0);
        check("rst_S",         S,              32'd0);
        check("rst_flags",     32'({OVF, NEG, CO}), 32'd0);
        RESET_N = 1'b1;
        #1;
        check("rst_in_ready",  32'(IN_READY),  32'd1);
        @(posedge CLK);
        #1;

        // Single-lane, 2-lane and 4-lane vectors with hand-computed results.
        send(32'h7FFFFFFF, 32'h00000001, 0, 2'b00, 0, 32'h80000000, 4'b0001, 4'b0000, 4'b0000, 1);
        idle(); drain();
        send(32'h00000005, 32'h00000007, 1, 2'b00, 0, 32'hFFFFFFFE, 4'b0000, 4'b0001, 4'b0000, 1);
        send(32'h7F01FF80, 32'h01010180, 0, 2'b10, 0, 32'h80020000, 4'b1001, 4'b0001, 4'b0011, 0);
        send(32'h7FFF8000, 32'h00010001, 1, 2'b01, 1,
             SAT_ON ? 32'h7FFE8000 : 32'h7FFE7FFF, 4'b0001, 4'b0001, 4'b0011, 0);
        send(32'h80000000, 32'h00010000, 1, 2'b01, 1,
             SAT_ON ? 32'h80000000 : 32'h7FFF0000, 4'b0010, 4'b0010, 4'b0011, 0);
        send(32'h00000080, 32'h000000FF, 0, 2'b10, 1,
             SAT_ON ? 32'h00000080 : 32'h0000007F, 4'b0001, 4'b0001, 4'b0001, 0);
        send(32'h0000FFFF, 32'h00000001, 0, 2'b11, 0, 32'h00010000, 4'b0000, 4'b0000, 4'b0000, 0);
        send(32'hFFFFFFFF, 32'h00010001, 0, 2'b01, 0, 32'h00000000, 4'b0000, 4'b0000, 4'b0011, 0);
        send(32'h00000000, 32'h01010101, 1, 2'b10, 0, 32'hFFFFFFFF, 4'b0000, 4'b1111, 4'b0000, 0);
        send(32'h01020304, 32'h01010101, 0, 2'b10, 1, 32'h02030405, 4'b0000, 4'b0000, 4'b0000, 0);
        idle(); drain();

        // Eight back-to-back beats with a 3-cycle consumer stall in the middle.
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    send(32'(i) * 32'h01010101, 32'h10203040, 0, 2'b10, 0,
                         32'(i) * 32'h01010101 + 32'h10203040, 4'b0000, 4'b0000, 4'b0000, 0);
                end
                idle();
            end
            begin
                repeat (4) @(posedge CLK);
                #1;
                OUT_READY = 1'b0;
                repeat (3) @(posedge CLK);
                #1;
                OUT_READY = 1'b1;
            end
        join
        drain();

        // Async reset with two beats in flight.
        send(32'h11111111, 32'h22222222, 0, 2'b00, 0, 32'h33333333, 4'b0000, 4'b0000, 4'b0000, 0);
        send(32'h44444444, 32'h11111111, 0, 2'b00, 0, 32'h55555555, 4'b0000, 4'b0000, 4'b0000, 0);
        idle();
        #1;
        check("inflight_valid", 32'(OUT_VALID), 32'd1);
        RESET_N = 1'b0;
        #1;
        check("async_rst_out_valid", 32'(OUT_VALID), 32'd0);
        check("async_rst_S",         S,              32'd0);
        check("async_rst_flags",     32'({OVF, NEG, CO}), 32'd0);
        sb.delete();
        @(posedge CLK);
        #1;
        RESET_N = 1'b1;
        @(posedge CLK);
        #1;
        send(32'h7FFFFFFF, 32'h00000001, 0, 2'b00, 0, 32'h80000000, 4'b0001, 4'b0000, 4'b0000, 1);
        idle(); drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
